// File: rtl/key_note_select.sv
// Piano key front end: two-flop synchronisers, per-key debounce, fixed-priority
// note select and a registered two-state FSM driving the tone generator.
module key_note_select #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int CNT_W           = 20
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [6:0]  keys_raw,
  output logic [18:0] half_period,
  output logic        note_on,
  output logic [2:0]  note_idx,
  output logic        note_change
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] PLAY = 1'b1;

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  // Terminal counts for a 50 MHz clock, indexed Do..Si.
  function automatic logic [18:0] note_lut(input logic [2:0] idx);
    case (idx)
      3'd0:    note_lut = 19'd95554;
      3'd1:    note_lut = 19'd85131;
      3'd2:    note_lut = 19'd75843;
      3'd3:    note_lut = 19'd71585;
      3'd4:    note_lut = 19'd63775;
      3'd5:    note_lut = 19'd56817;
      3'd6:    note_lut = 19'd50619;
      default: note_lut = 19'd0;
    endcase
  endfunction

  logic [6:0]       s1_q, s2_q;
  logic [6:0]       stable_q, stable_d;
  logic [CNT_W-1:0] cnt_q [7];
  logic [CNT_W-1:0] cnt_d [7];

  logic [0:0]  state_q, state_d;
  logic [18:0] hp_q, hp_d;
  logic        on_q, on_d;
  logic [2:0]  idx_q, idx_d;
  logic        chg_q, chg_d;

  logic [2:0]  sel_s;
  logic        sel_valid_s;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q <= 7'd0;
      s2_q <= 7'd0;
    end else begin
      s1_q <= keys_raw;
      s2_q <= s1_q;
    end
  end

  // Any disagreement with the stable value must persist DEBOUNCE_CYCLES in a row.
  always_comb begin
    stable_d = stable_q;
    cnt_d    = cnt_q;
    for (int i = 0; i < 7; i++) begin
      if (s2_q[i] == stable_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] == CNT_MAX) begin
        stable_d[i] = s2_q[i];
        cnt_d[i]    = '0;
      end else begin
        cnt_d[i] = cnt_q[i] + CNT_ONE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stable_q <= 7'd0;
      for (int i = 0; i < 7; i++) cnt_q[i] <= '0;
    end else begin
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
    end
  end

  // Descending scan so the lowest set index (Do) is the last, winning assignment.
  always_comb begin
    sel_s = 3'd0;
    for (int i = 6; i >= 0; i--) begin
      if (stable_q[i]) sel_s = 3'(i);
    end
    sel_valid_s = |stable_q;
  end

  always_comb begin
    state_d = state_q;
    hp_d    = hp_q;
    on_d    = on_q;
    idx_d   = idx_q;
    chg_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (sel_valid_s) begin
          state_d = PLAY;
          idx_d   = sel_s;
          hp_d    = note_lut(sel_s);
          on_d    = 1'b1;
          chg_d   = 1'b1;
        end else begin
          on_d = 1'b0;
          hp_d = 19'd0;
        end
      end
      PLAY: begin
        if (!sel_valid_s) begin
          state_d = IDLE;
          on_d    = 1'b0;
          hp_d    = 19'd0;
        end else if (sel_s != idx_q) begin
          idx_d = sel_s;
          hp_d  = note_lut(sel_s);
          chg_d = 1'b1;
        end else begin
          on_d = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        on_d    = 1'b0;
        hp_d    = 19'd0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      hp_q    <= 19'd0;
      on_q    <= 1'b0;
      idx_q   <= 3'd0;
      chg_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      hp_q    <= hp_d;
      on_q    <= on_d;
      idx_q   <= idx_d;
      chg_q   <= chg_d;
    end
  end

  assign half_period = hp_q;
  assign note_on     = on_q;
  assign note_idx    = idx_q;
  assign note_change = chg_q;

endmodule

// File: doc/key_note_select.md
Name: key_note_select

Overview:
- Front end of the piano tone path; sits directly upstream of the per-note square-wave tone generators.
- Synchronises and debounces the seven raw piano keys (Do, Re, Mi, Fa, Sol, La, Si).
- Selects one active note by fixed priority.
- Drives the selected note's half-period terminal count, a note-active flag and a change strobe to the downstream tone generator and speaker mux.
- System clock is 50 MHz; terminal counts are sized for that clock.

Parameters:
- DEBOUNCE_CYCLES, 500000, consecutive stable cycles required before a key's debounced state flips (10 ms at 50 MHz); legal range 2..1048575.
- CNT_W, 20, width of each per-key debounce counter; must satisfy 2^CNT_W > DEBOUNCE_CYCLES.

Ports:
- clk  input  1  system clock, 50 MHz; all state changes on its rising edge.
- rst  input  1  synchronous, active-high reset, sampled on the rising edge of clk.
- keys_raw  input  7  asynchronous mechanical keys, active-high; bit0=Do, 1=Re, 2=Mi, 3=Fa, 4=Sol, 5=La, 6=Si.
- half_period  output  19  terminal count for the downstream toggle counter; the speaker toggles when the counter equals this value.
- note_on  output  1  high while a note is selected.
- note_idx  output  3  index of the selected note, 0..6.
- note_change  output  1  one-cycle pulse when a note starts, or when the selected note changes while playing.

Behaviour:
- Reset:
  - Synchronous, active-high.
  - Clears sync flops, debounced states, debounce counters and FSM (FSM -> IDLE).
  - Outputs during and after reset: half_period=0, note_on=0, note_idx=0, note_change=0.
  - Reset mid-note stops output on the next edge.
  - A key held through reset must re-debounce (full DEBOUNCE_CYCLES) after rst falls.
- Synchroniser:
  - Two flops per key (s1, s2), no reset bypass.
- Debounce, per key, each edge:
  - If s2 == stable: cnt <= 0.
  - Else if cnt == DEBOUNCE_CYCLES-1: stable <= s2, cnt <= 0.
  - Else: cnt <= cnt+1.
  - Any bounce back to the stable value restarts the count from 0.
- Priority select:
  - Combinational over the stable vector; lowest set index wins (Do highest priority).
  - sel_valid = OR of stable.
- Half-period lookup (terminal counts, 50 MHz):
  - Do 95554
  - Re 85131
  - Mi 75843
  - Fa 71585
  - Sol 63775
  - La 56817
  - Si 50619
- FSM, two states, all outputs registered:
  - IDLE: if sel_valid -> PLAY; load note_idx=sel, half_period=LUT(sel), note_on=1, note_change=1.
  - PLAY, sel_valid and sel != note_idx: stay in PLAY; reload note_idx and half_period; note_change=1.
  - PLAY, sel_valid and sel == note_idx: hold all outputs; note_change=0.
  - PLAY, !sel_valid: -> IDLE; note_on=0, half_period=0, note_idx holds its last value, note_change=0.
- Latency: keys_raw stable before edge k -> stable flips at edge k+1+DEBOUNCE_CYCLES -> outputs update at edge k+2+DEBOUNCE_CYCLES.
- Simultaneous events:
  - Several keys debounced in the same cycle: only the priority winner is reported.
  - Releasing the winner while a lower-priority key stays held: switch to that key with note_change=1, no IDLE gap.
- note_change is never high on two consecutive cycles unless sel changes on consecutive cycles.
- half_period is 0 whenever note_on=0.

Test Plan (bench uses DEBOUNCE_CYCLES=4):
- Reset, then keys_raw=0000000 for 20 cycles -> note_on=0, half_period=0, note_change never asserted.
- keys_raw[6] rises clean before edge k -> at edge k+6: note_on=1, note_idx=6, half_period=50619, note_change high for exactly 1 cycle.
- keys_raw[0] toggling every 2 cycles for 30 cycles, then held high -> no output change during the bounce; held high before edge j -> outputs update at edge j+6: note_idx=0, half_period=95554.
- Hold La (bit5) until playing, then press Re (bit1) -> switch to note_idx=1, half_period=85131, one note_change pulse; release Re -> note_idx=5, half_period=56817, one pulse.
- While Sol is playing, assert rst for 1 cycle with the key held -> next edge: note_on=0, half_period=0; note returns 6 cycles after rst falls, half_period=63775.
- Press Mi and Fa together -> note_idx=2, half_period=75843; release both -> note_on=0, half_period=0, note_idx stays 2.
